// File: rtl/mips_reset_pkg.sv
// mips_reset_pkg
// Shared definitions for the MIPS reset sequencer:
//   - seq_state_t   : sequencer state encoding (SYNC, HOLD, RUN)
//   - SOFT_CNT_W    : width of the re-sequence counter output
//   - SOFT_CNT_MAX  : saturation value of that counter
//   - cnt_width_ok  : checks that the sequence counter can reach the last release point
package mips_reset_pkg;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2
   } seq_state_t;

   localparam int SOFT_CNT_W = 8;
   localparam logic [SOFT_CNT_W-1:0] SOFT_CNT_MAX = 8'd255;

   // True when a CNT_W-bit counter can count up to the release point of the last channel.
   function automatic bit cnt_width_ok(input int cnt_w, input int hold_cycles,
                                       input int num_out, input int stagger_cycles);
      longint max_cnt;
      longint last_rel;
      max_cnt  = (longint'(1) << cnt_w) - 1;
      last_rel = longint'(hold_cycles) + longint'(num_out - 1) * longint'(stagger_cycles);
      return (max_cnt >= last_rel);
   endfunction

endpackage

// File: rtl/mips_reset_sync.sv
// mips_reset_sync
// Release synchronizer for the raw board reset: a STAGES-deep flop chain with its
// data input tied to 1. The whole chain clears asynchronously while reset is low,
// and a 1 walks through it once reset rises.
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-low reset
//   chain  out  [STAGES-1:0] every stage of the chain, stage 0 first
module mips_reset_sync
   import mips_reset_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic [STAGES-1:0] chain
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/mips_reset_sequencer.sv
// mips_reset_sequencer
// Reset generator for the MIPS core and its peripherals. Synchronizes release of
// the raw active-low board reset, then releases NUM_OUT active-high channel resets
// in staggered order (channel 0 first). A soft-reset request re-runs the release
// sequence without re-running the synchronizer.
// Optional watchdog: define MIPS_RESET_SEQ_WDT_EN to re-sequence when wdt_kick
// stays quiet for WDT_CYCLES cycles in RUN.
// Ports:
//   clk             in   clock
//   reset           in   asynchronous active-low reset
//   soft_rst_req    in   synchronous request to restart the sequence
//   wdt_kick        in   watchdog heartbeat (unused without the watchdog)
//   rst_out         out  [NUM_OUT-1:0] per-channel active-high resets
//   all_released    out  every channel released (state RUN)
//   seq_busy        out  sequencing in progress (state not RUN)
//   soft_rst_count  out  [7:0] saturating count of soft/watchdog re-sequences
//   wdt_fired       out  sticky: watchdog caused a re-sequence
module mips_reset_sequencer
   import mips_reset_pkg::*;
#(
   parameter int NUM_OUT        = 2,
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_CYCLES    = 4,
   parameter int STAGGER_CYCLES = 2,
   parameter int CNT_W          = 8,
   parameter int WDT_CYCLES     = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  soft_rst_req,
   input  logic                  wdt_kick,
   output logic [NUM_OUT-1:0]    rst_out,
   output logic                  all_released,
   output logic                  seq_busy,
   output logic [SOFT_CNT_W-1:0] soft_rst_count,
   output logic                  wdt_fired
);

   if (!cnt_width_ok(CNT_W, HOLD_CYCLES, NUM_OUT, STAGGER_CYCLES)) begin : g_cnt_w_check
      $error("mips_reset_sequencer: CNT_W too narrow for HOLD_CYCLES + (NUM_OUT-1)*STAGGER_CYCLES");
   end

   localparam logic [CNT_W-1:0] LAST_REL = CNT_W'(HOLD_CYCLES + (NUM_OUT - 1) * STAGGER_CYCLES);

   seq_state_t                state_reg, state_next;
   logic [CNT_W-1:0]          cnt_reg, cnt_next, cnt_inc;
   logic [NUM_OUT-1:0]        rst_reg, rst_next;
   logic [SOFT_CNT_W-1:0]     soft_cnt_reg, soft_cnt_next;
   logic [SYNC_STAGES-1:0]    sync_chain;
   logic [NUM_OUT-1:0]        release_hit;
   logic                      sync_arrive;
   logic                      wdt_timeout;
   logic                      resequence;

   mips_reset_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .chain (sync_chain)
   );

   // The 1 is about to land in the final stage on this edge, so HOLD begins on the
   // same edge the synchronizer completes.
   assign sync_arrive = sync_chain[SYNC_STAGES-2] & ~sync_chain[SYNC_STAGES-1];

   assign cnt_inc = cnt_reg + 1'b1;

   // Channel gi drops on the edge where the counter becomes its release point.
   for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_release
      assign release_hit[gi] = (cnt_inc == CNT_W'(HOLD_CYCLES + gi * STAGGER_CYCLES));
   end

   assign resequence = (state_reg != SYNC) && (soft_rst_req || wdt_timeout);

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      rst_next      = rst_reg;
      soft_cnt_next = soft_cnt_reg;

      case (state_reg)
         SYNC: begin
            if (sync_arrive) begin
               state_next = HOLD;
               cnt_next   = '0;
            end
         end
         HOLD: begin
            cnt_next = cnt_inc;
            rst_next = rst_reg & ~release_hit;
            if (cnt_inc == LAST_REL) begin
               state_next = RUN;
            end
         end
         RUN: begin
         end
         default: begin
            state_next = SYNC;
         end
      endcase

      // A soft request or watchdog timeout on the same cycle is one re-sequence.
      if (resequence) begin
         state_next = HOLD;
         cnt_next   = '0;
         rst_next   = '1;
         if (soft_cnt_reg != SOFT_CNT_MAX) begin
            soft_cnt_next = soft_cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= SYNC;
         cnt_reg      <= '0;
         rst_reg      <= '1;
         soft_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         rst_reg      <= rst_next;
         soft_cnt_reg <= soft_cnt_next;
      end
   end

`ifdef MIPS_RESET_SEQ_WDT_EN
   localparam int WDT_W = $clog2(WDT_CYCLES + 1);

   logic [WDT_W-1:0] wdt_cnt_reg;
   logic             wdt_fired_reg;

   assign wdt_timeout = (state_reg == RUN) && (wdt_cnt_reg == WDT_W'(WDT_CYCLES)) && !wdt_kick;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdt_cnt_reg   <= '0;
         wdt_fired_reg <= 1'b0;
      end else begin
         // Counter only runs in RUN; a kick or a timeout restarts it.
         if ((state_reg != RUN) || wdt_kick || wdt_timeout) begin
            wdt_cnt_reg <= '0;
         end else begin
            wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
         end
         if (wdt_timeout) begin
            wdt_fired_reg <= 1'b1;
         end
      end
   end

   assign wdt_fired = wdt_fired_reg;
`else
   logic unused_wdt;

   assign wdt_timeout = 1'b0;
   assign wdt_fired   = 1'b0;
   assign unused_wdt  = wdt_kick ^ (WDT_CYCLES != 0);
`endif

   assign rst_out        = rst_reg;
   assign all_released   = (state_reg == RUN);
   assign seq_busy       = (state_reg != RUN);
   assign soft_rst_count = soft_cnt_reg;

endmodule

// File: tb/tb_mips_reset_sequencer.sv
// tb_mips_reset_sequencer
// Self-checking bench for mips_reset_sequencer. Expected output words are pushed to
// a queue as stimulus is applied and popped/compared once per clock on the falling
// edge. A second instance (NUM_OUT=4, STAGGER_CYCLES=0) shares clock and reset.
// The watchdog scenario is exercised when MIPS_RESET_SEQ_WDT_EN is defined.
module tb_mips_reset_sequencer;

   localparam int SS        = 2;
   localparam int H         = 4;
   localparam int S         = 2;
   localparam int RST_BASE  = SS + H;   // edge releasing channel 0 after reset rises
   localparam int SOFT_BASE = H + 1;    // same, counting the request-sampling edge as 1

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       soft_rst_req = 1'b0;
   logic       wdt_kick = 1'b1;
   logic [1:0] rst_out;
   logic       all_released, seq_busy, wdt_fired;
   logic [7:0] soft_rst_count;

   logic [3:0] rst_out2;
   logic       all_released2, seq_busy2, wdt_fired2;
   logic [7:0] soft_rst_count2;

   mips_reset_sequencer #(
      .NUM_OUT(2), .SYNC_STAGES(SS), .HOLD_CYCLES(H), .STAGGER_CYCLES(S),
      .CNT_W(8), .WDT_CYCLES(10)
   ) dut (
      .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req), .wdt_kick(wdt_kick),
      .rst_out(rst_out), .all_released(all_released), .seq_busy(seq_busy),
      .soft_rst_count(soft_rst_count), .wdt_fired(wdt_fired)
   );

   mips_reset_sequencer #(
      .NUM_OUT(4), .SYNC_STAGES(SS), .HOLD_CYCLES(H), .STAGGER_CYCLES(0),
      .CNT_W(8), .WDT_CYCLES(10)
   ) dut2 (
      .clk(clk), .reset(reset), .soft_rst_req(1'b0), .wdt_kick(1'b1),
      .rst_out(rst_out2), .all_released(all_released2), .seq_busy(seq_busy2),
      .soft_rst_count(soft_rst_count2), .wdt_fired(wdt_fired2)
   );

   always #5 clk = ~clk;

   // Word layout: {rst_out, all_released, seq_busy, soft_rst_count, wdt_fired}
   logic [12:0] sb[$];
   logic [14:0] sb2[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_count = 8'd0;
   logic        exp_wdt = 1'b0;

   // Expected main-DUT word at edge e of a sequence whose channel 0 drops at edge base.
   function automatic logic [12:0] exp_word(input int e, input int base,
                                            input logic [7:0] c, input logic w);
      logic [1:0] r;
      logic       a;
      r[0] = (e < base);
      r[1] = (e < base + S);
      a    = (e >= base + S);
      return {r, a, ~a, c, w};
   endfunction

   task automatic push_seq(input int n, input int base, input bit with2);
      for (int e = 1; e <= n; e++) begin
         sb.push_back(exp_word(e, base, exp_count, exp_wdt));
         if (with2) begin
            sb2.push_back({((e < base) ? 4'hF : 4'h0), 1'(e >= base), 1'(e < base), 8'd0, 1'b0});
         end
      end
   endtask

   task automatic bump_count();
      if (exp_count != 8'd255) exp_count = exp_count + 8'd1;
   endtask

   task automatic test_reset();
      logic [12:0] got, exp;
      logic [14:0] got2, exp2;
      reset = 1'b0;
      soft_rst_req = 1'b1;      // must be ignored while in SYNC
      repeat (3) @(negedge clk);
      got = {rst_out, all_released, seq_busy, soft_rst_count, wdt_fired};
      exp = {2'b11, 1'b0, 1'b1, 8'd0, 1'b0};
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL reset_hold: got %b want %b", got, exp);
      end
      exp_count = 8'd0;
      exp_wdt = 1'b0;
      push_seq(10, RST_BASE, 1'b1);
      reset = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         if (e == SS) soft_rst_req = 1'b0;
         exp = sb.pop_front();
         got = {rst_out, all_released, seq_busy, soft_rst_count, wdt_fired};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL reset_seq edge %0d: got %b want %b", e, got, exp);
         end
         exp2 = sb2.pop_front();
         got2 = {rst_out2, all_released2, seq_busy2, soft_rst_count2, wdt_fired2};
         n_cmp++;
         if (got2 !== exp2) begin
            n_bad++;
            $display("FAIL stagger0_seq edge %0d: got %b want %b", e, got2, exp2);
         end
      end
      $display("test_reset: release sequence from SYNC checked over 10 edges");
   endtask

   task automatic test_soft_run();
      logic [12:0] got, exp;
      bump_count();
      soft_rst_req = 1'b1;
      push_seq(8, SOFT_BASE, 1'b0);
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         soft_rst_req = 1'b0;
         exp = sb.pop_front();
         got = {rst_out, all_released, seq_busy, soft_rst_count, wdt_fired};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL soft_run edge %0d: got %b want %b", e, got, exp);
         end
      end
      $display("test_soft_run: soft request in RUN, count now %0d", exp_count);
   endtask

   task automatic test_soft_in_hold();
      logic [12:0] got, exp;
      bump_count();
      soft_rst_req = 1'b1;
      push_seq(6, SOFT_BASE, 1'b0);       // ends with HOLD cnt = 5, channel 0 released
      for (int e = 1; e <= 6; e++) begin
         @(negedge clk);
         soft_rst_req = 1'b0;
         exp = sb.pop_front();
         got = {rst_out, all_released, seq_busy, soft_rst_count, wdt_fired};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL hold_pre edge %0d: got %b want %b", e, got, exp);
         end
      end
      bump_count();
      soft_rst_req = 1'b1;
      push_seq(8, SOFT_BASE, 1'b0);
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         soft_rst_req = 1'b0;
         exp = sb.pop_front();
         got = {rst_out, all_released, seq_busy, soft_rst_count, wdt_fired};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL hold_restart edge %0d: got %b want %b", e, got, exp);
         end
      end
      $display("test_soft_in_hold: restart at cnt 5, count now %0d", exp_count);
   endtask

`ifdef MIPS_RESET_SEQ_WDT_EN
   task automatic test_wdt();
      logic [12:0] got, exp;
      wdt_kick = 1'b0;
      for (int e = 1; e <= 10; e++) sb.push_back(exp_word(99, SOFT_BASE, exp_count, exp_wdt));
      bump_count();
      exp_wdt = 1'b1;
      push_seq(8, SOFT_BASE, 1'b0);       // timeout edge is edge 11 into RUN
      for (int e = 1; e <= 18; e++) begin
         @(negedge clk);
         if (e == 11) wdt_kick = 1'b1;
         exp = sb.pop_front();
         got = {rst_out, all_released, seq_busy, soft_rst_count, wdt_fired};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL wdt_timeout edge %0d: got %b want %b", e, got, exp);
         end
      end
      for (int e = 1; e <= 40; e++) sb.push_back(exp_word(99, SOFT_BASE, exp_count, exp_wdt));
      for (int e = 1; e <= 40; e++) begin
         wdt_kick = ((e % 5) == 0);
         @(negedge clk);
         exp = sb.pop_front();
         got = {rst_out, all_released, seq_busy, soft_rst_count, wdt_fired};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL wdt_kicked edge %0d: got %b want %b", e, got, exp);
         end
      end
      wdt_kick = 1'b1;
      $display("test_wdt: timeout re-sequenced, periodic kicks held RUN");
   endtask
`else
   task automatic test_wdt();
      logic [12:0] got, exp;
      wdt_kick = 1'b0;
      for (int e = 1; e <= 30; e++) sb.push_back(exp_word(99, SOFT_BASE, exp_count, 1'b0));
      for (int e = 1; e <= 30; e++) begin
         @(negedge clk);
         exp = sb.pop_front();
         got = {rst_out, all_released, seq_busy, soft_rst_count, wdt_fired};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL wdt_absent edge %0d: got %b want %b", e, got, exp);
         end
      end
      wdt_kick = 1'b1;
      $display("test_wdt: no watchdog in this build, RUN held without kicks");
   endtask
`endif

   task automatic test_glitch();
      logic [12:0] got, exp;
      logic [14:0] got2, exp2;
      bump_count();
      soft_rst_req = 1'b1;
      push_seq(3, SOFT_BASE, 1'b0);
      for (int e = 1; e <= 3; e++) begin
         @(negedge clk);
         soft_rst_req = 1'b0;
         exp = sb.pop_front();
         got = {rst_out, all_released, seq_busy, soft_rst_count, wdt_fired};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL glitch_pre edge %0d: got %b want %b", e, got, exp);
         end
      end
      #2 reset = 1'b0;
      #1;
      got = {rst_out, all_released, seq_busy, soft_rst_count, wdt_fired};
      exp = {2'b11, 1'b0, 1'b1, 8'd0, 1'b0};
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL glitch_async: got %b want %b", got, exp);
      end
      got2 = {rst_out2, all_released2, seq_busy2, soft_rst_count2, wdt_fired2};
      exp2 = {4'hF, 1'b0, 1'b1, 8'd0, 1'b0};
      n_cmp++;
      if (got2 !== exp2) begin
         n_bad++;
         $display("FAIL glitch_async2: got %b want %b", got2, exp2);
      end
      exp_count = 8'd0;
      exp_wdt = 1'b0;
      push_seq(10, RST_BASE, 1'b1);
      #1 reset = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         exp = sb.pop_front();
         got = {rst_out, all_released, seq_busy, soft_rst_count, wdt_fired};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL glitch_seq edge %0d: got %b want %b", e, got, exp);
         end
         exp2 = sb2.pop_front();
         got2 = {rst_out2, all_released2, seq_busy2, soft_rst_count2, wdt_fired2};
         n_cmp++;
         if (got2 !== exp2) begin
            n_bad++;
            $display("FAIL glitch_seq2 edge %0d: got %b want %b", e, got2, exp2);
         end
      end
      $display("test_glitch: short reset pulse restarted from SYNC");
   endtask

   task automatic test_saturate();
      logic [12:0] got, exp;
      soft_rst_req = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         bump_count();
         sb.push_back(exp_word(1, SOFT_BASE, exp_count, exp_wdt));
      end
      for (int e = 2; e <= 9; e++) sb.push_back(exp_word(e, SOFT_BASE, exp_count, exp_wdt));
      for (int k = 1; k <= 308; k++) begin
         @(negedge clk);
         if (k == 300) soft_rst_req = 1'b0;
         exp = sb.pop_front();
         got = {rst_out, all_released, seq_busy, soft_rst_count, wdt_fired};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL saturate edge %0d: got %b want %b", k, got, exp);
         end
      end
      $display("test_saturate: 300 held requests, count %0d", exp_count);
   endtask

   initial begin
      test_reset();
      test_soft_run();
      test_soft_in_hold();
      test_wdt();
      test_glitch();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
